ext_raz_pulse_gen: RTL and testbench

Converts the single-cycle delayed reset request from the external-RAZ delay stage into the analog reset pulse driven to the ASIC RAZ_CHN pin. Sits directly downstream of the RAZ delay counter in the S-curve test path. It applies a selectable pulse width and a post-pulse hold-off, and drops requests that arrive while busy. Optional statistics counters report issued and dropped pulses to the slow-control register map.

---
 rtl/ext_raz_pulse_gen_pkg.sv | 36 +++
 rtl/ext_raz_pulse_gen_if.sv | 54 +++++
 rtl/ext_raz_pulse_gen_sat_counter.sv | 33 +++
 rtl/ext_raz_pulse_gen.sv | 149 ++++++++++++++
 tb/tb_ext_raz_pulse_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_raz_pulse_gen_pkg.sv
// ----------------------------------------------------------------------------
// raz_pkg
//   Shared definitions for the external-RAZ pulse generator:
//     - raz_state_e      : FSM state encoding (IDLE / PULSE / HOLDOFF)
//     - RAZ_W_*          : pulse widths in 40 MHz clock cycles
//     - WIDTH_CNT_W      : width of the pulse-width down-counter
//     - raz_width_decode : RazWidthSel -> pulse width in cycles
// ----------------------------------------------------------------------------
package raz_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } raz_state_e;

  localparam int RAZ_W_75NS  = 3;
  localparam int RAZ_W_250NS = 10;
  localparam int RAZ_W_500NS = 20;
  localparam int RAZ_W_1US   = 40;

  // Wide enough for the longest pulse (40 cycles).
  localparam int WIDTH_CNT_W = 6;

  function automatic logic [WIDTH_CNT_W-1:0] raz_width_decode(input logic [1:0] sel);
    logic [WIDTH_CNT_W-1:0] w;
    case (sel)
      2'b00:   w = WIDTH_CNT_W'(RAZ_W_75NS);
      2'b01:   w = WIDTH_CNT_W'(RAZ_W_250NS);
      2'b10:   w = WIDTH_CNT_W'(RAZ_W_500NS);
      default: w = WIDTH_CNT_W'(RAZ_W_1US);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ext_raz_pulse_gen_if.sv
// ----------------------------------------------------------------------------
// ext_raz_pulse_gen_if
//   Groups the request/mode inputs and the pulse/status outputs of the
//   external-RAZ pulse generator.
//   Parameter CNT_WIDTH must match the generator's CNT_WIDTH.
//   Signals:
//     SingleRaz_en    one-cycle request pulse from the RAZ delay stage
//     ExternalRaz_en  mode enable; requests ignored while low
//     RazWidthSel     pulse width select (00=3, 01=10, 10=20, 11=40 cycles)
//     CntClear        synchronous clear of both statistics counters
//     RAZ_CHN         active-high RAZ pulse to the ASIC
//     RazBusy         high while a pulse or its hold-off is in progress
//     RazIssued       accepted request count (0 when statistics are off)
//     RazDropped      rejected request count (0 when statistics are off)
//   Modports:
//     master : request side (drives the controls, observes the outputs)
//     slave  : the pulse generator itself
// ----------------------------------------------------------------------------
interface ext_raz_pulse_gen_if #(
  parameter int CNT_WIDTH = 16
) ();

  logic                 SingleRaz_en;
  logic                 ExternalRaz_en;
  logic [1:0]           RazWidthSel;
  logic                 CntClear;
  logic                 RAZ_CHN;
  logic                 RazBusy;
  logic [CNT_WIDTH-1:0] RazIssued;
  logic [CNT_WIDTH-1:0] RazDropped;

  modport master (
    output SingleRaz_en,
    output ExternalRaz_en,
    output RazWidthSel,
    output CntClear,
    input  RAZ_CHN,
    input  RazBusy,
    input  RazIssued,
    input  RazDropped
  );

  modport slave (
    input  SingleRaz_en,
    input  ExternalRaz_en,
    input  RazWidthSel,
    input  CntClear,
    output RAZ_CHN,
    output RazBusy,
    output RazIssued,
    output RazDropped
  );

endinterface

// File: rtl/ext_raz_pulse_gen_sat_counter.sv
// ----------------------------------------------------------------------------
// raz_sat_counter
//   Saturating up-counter for the RAZ statistics.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset (count -> 0)
//     inc    increment by one this cycle (held at all-ones once reached)
//     clr    synchronous clear; wins over inc in the same cycle
//     count  current count
// ----------------------------------------------------------------------------
module raz_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/ext_raz_pulse_gen.sv
// ----------------------------------------------------------------------------
// ext_raz_pulse_gen
//   Turns the one-cycle delayed reset request from the external-RAZ delay
//   stage into the RAZ_CHN pulse driven to the ASIC. A request accepted at
//   clock edge N drives RAZ_CHN high after edge N for exactly W cycles
//   (W from RazWidthSel, latched at acceptance), then holds the generator
//   busy for HOLDOFF_CYCLES more cycles. Requests that arrive while busy are
//   dropped; requests while ExternalRaz_en is low are ignored.
//
//   Optional feature macro: RAZ_STAT_EN
//     defined   : saturating RazIssued / RazDropped counters with CntClear
//     undefined : RazIssued / RazDropped tied to 0, CntClear unused
//
//   Parameters:
//     HOLDOFF_CYCLES  idle cycles forced after each pulse (0..255)
//     CNT_WIDTH       statistics counter width (must match the interface)
//   Ports:
//     Clk      40 MHz system clock
//     reset_n  asynchronous active-low reset; RAZ_CHN drops immediately
//     bus      ext_raz_pulse_gen_if slave modport (requests, pulse, status)
// ----------------------------------------------------------------------------
module ext_raz_pulse_gen
  import raz_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  ext_raz_pulse_gen_if.slave    bus
);

  localparam bit         HOLD_EN   = (HOLDOFF_CYCLES != 0);
  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF_CYCLES);

  raz_state_e             state_q, state_d;
  logic [WIDTH_CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic                   raz_q;
  logic                   busy_q;
  logic                   req;
  logic                   accept;
  logic                   drop;

  assign req = bus.SingleRaz_en && bus.ExternalRaz_en;

  // State and counter registers
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      width_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      width_cnt_q <= width_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state logic. ExternalRaz_en only gates acceptance; once a pulse
  // starts it always runs to completion, so the ASIC never sees a runt pulse.
  always_comb begin
    state_d     = state_q;
    width_cnt_d = width_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    accept      = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept      = 1'b1;
          width_cnt_d = raz_width_decode(bus.RazWidthSel);
          state_d     = PULSE;
        end
      end
      PULSE: begin
        drop = req;
        // WidthCnt==1 marks the last high cycle of the pulse.
        if (width_cnt_q <= WIDTH_CNT_W'(1)) begin
          width_cnt_d = '0;
          if (HOLD_EN) begin
            state_d    = HOLDOFF;
            hold_cnt_d = HOLD_INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          width_cnt_d = width_cnt_q - WIDTH_CNT_W'(1);
        end
      end
      HOLDOFF: begin
        drop = req;
        if (hold_cnt_q <= 8'd1) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from flops (decoded from the next state) so the
  // pin to the ASIC is glitch-free and aligned with the state change.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      raz_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      raz_q  <= (state_d == PULSE);
      busy_q <= (state_d != IDLE);
    end
  end

  assign bus.RAZ_CHN = raz_q;
  assign bus.RazBusy = busy_q;

`ifdef RAZ_STAT_EN
  raz_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_issued_cnt (
    .clk   (Clk),
    .rst_n (reset_n),
    .inc   (accept),
    .clr   (bus.CntClear),
    .count (bus.RazIssued)
  );

  raz_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_dropped_cnt (
    .clk   (Clk),
    .rst_n (reset_n),
    .inc   (drop),
    .clr   (bus.CntClear),
    .count (bus.RazDropped)
  );
`else
  // Statistics compiled out: counters read as constant zero.
  logic unused_stat;
  assign unused_stat    = ^{bus.CntClear, accept, drop};
  assign bus.RazIssued  = '0;
  assign bus.RazDropped = '0;
`endif

endmodule

// File: tb/tb_ext_raz_pulse_gen.sv
// ----------------------------------------------------------------------------
// tb_ext_raz_pulse_gen
//   Scoreboard bench for ext_raz_pulse_gen. A reference model tracks, per
//   clock edge, when the generator is free again and which pulse widths must
//   appear; each accepted request pushes its width into a queue. A monitor
//   on the opposite clock edge measures each RAZ_CHN pulse and pops/compares,
//   and also compares busy, pin level and the statistics counters.
//   Statistics expectations follow the RAZ_STAT_EN macro.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ext_raz_pulse_gen;

  localparam int H    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef RAZ_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic Clk = 1'b0;
  logic reset_n;
  always #5 Clk = ~Clk;

  ext_raz_pulse_gen_if #(.CNT_WIDTH(CW)) bus ();

  ext_raz_pulse_gen #(
    .HOLDOFF_CYCLES (H),
    .CNT_WIDTH      (CW)
  ) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc      = 0;
  int busy_end = -1;   // last edge at which the generator is still busy
  int raz_end  = -1;   // pin is high after edges strictly below this
  int iss_m    = 0;
  int drp_m    = 0;
  bit exp_raz  = 1'b0;
  bit exp_busy = 1'b0;
  int sb_q[$];

  function automatic int width_of(input logic [1:0] s);
    case (s)
      2'b00:   return 3;
      2'b01:   return 10;
      2'b10:   return 20;
      default: return 40;
    endcase
  endfunction

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_end = -1;
      raz_end  = -1;
      iss_m    = 0;
      drp_m    = 0;
      exp_raz  = 1'b0;
      exp_busy = 1'b0;
      sb_q.delete();
    end else begin
      bit acc;
      bit drp;
      int w;
      cyc++;
      acc = 1'b0;
      drp = 1'b0;
      if (bus.SingleRaz_en && bus.ExternalRaz_en) begin
        if (cyc > busy_end) begin
          w        = width_of(bus.RazWidthSel);
          raz_end  = cyc + w;
          busy_end = cyc + w + H;
          sb_q.push_back(w);
          acc = 1'b1;
        end else begin
          drp = 1'b1;
        end
      end
      if (bus.CntClear) begin
        iss_m = 0;
        drp_m = 0;
      end else begin
        if (acc && iss_m < CMAX) iss_m++;
        if (drp && drp_m < CMAX) drp_m++;
      end
      exp_raz  = (cyc < raz_end);
      exp_busy = (cyc < busy_end);
    end
  end

  // ---------------- monitor ----------------
  bit in_p = 1'b0;
  int plen = 0;

  always @(negedge Clk) begin
    if (!reset_n) begin
      in_p = 1'b0;
      plen = 0;
    end else begin
      check("raz_level",   int'(bus.RAZ_CHN), int'(exp_raz));
      check("busy_level",  int'(bus.RazBusy), int'(exp_busy));
      check("issued_cnt",  int'(bus.RazIssued),  STAT ? iss_m : 0);
      check("dropped_cnt", int'(bus.RazDropped), STAT ? drp_m : 0);
      if (bus.RAZ_CHN) begin
        if (!in_p) begin
          in_p = 1'b1;
          plen = 1;
        end else begin
          plen++;
        end
      end else if (in_p) begin
        in_p = 1'b0;
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", plen, 0);
        end else begin
          check("pulse_width", plen, sb_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit e, input bit [1:0] s, input bit c);
    bus.SingleRaz_en   = r;
    bus.ExternalRaz_en = e;
    bus.RazWidthSel    = s;
    bus.CntClear       = c;
    @(posedge Clk);
    #1;
    bus.SingleRaz_en = 1'b0;
    bus.CntClear     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bus.ExternalRaz_en, bus.RazWidthSel, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int raz_cnt;
    int busy_cnt;

    reset_n            = 1'b0;
    bus.SingleRaz_en   = 1'b0;
    bus.ExternalRaz_en = 1'b0;
    bus.RazWidthSel    = 2'b00;
    bus.CntClear       = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_raz",     int'(bus.RAZ_CHN), 0);
    check("reset_busy",    int'(bus.RazBusy), 0);
    check("reset_issued",  int'(bus.RazIssued), 0);
    check("reset_dropped", int'(bus.RazDropped), 0);
    reset_n = 1'b1;
    idle(2);

    // Single request, width 10: pin high 10 cycles, busy 14 cycles.
    step(1'b1, 1'b1, 2'b01, 1'b0);
    raz_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (bus.RAZ_CHN) raz_cnt++;
      if (bus.RazBusy) busy_cnt++;
    end
    check("single_raz_cycles",  raz_cnt, 10);
    check("single_busy_cycles", busy_cnt, 14);
    check("single_issued", int'(bus.RazIssued), STAT ? 1 : 0);
    @(posedge Clk);
    #1;

    // Every width select.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 1'b1, 2'(s), 1'b0);
      idle(50);
    end

    // Requests at offsets 0, 1, 5, 15 (width 10, hold-off 4).
    step(1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    idle(9);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    idle(20);
    check("sched_issued",  int'(bus.RazIssued),  STAT ? 2 : 0);
    check("sched_dropped", int'(bus.RazDropped), STAT ? 2 : 0);

    // Mode disabled: no pulse, no count.
    step(1'b1, 1'b0, 2'b11, 1'b0);
    idle(10);
    check("disabled_no_pulse", int'(bus.RAZ_CHN), 0);

    // Mode dropped during a 20-cycle pulse: pulse still completes.
    step(1'b1, 1'b1, 2'b10, 1'b0);
    idle(2);
    bus.ExternalRaz_en = 1'b0;
    idle(40);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 6) == 0, ($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 64) == 0);
    end
    idle(60);

    // Saturation: 17 accepted requests on a 4-bit counter.
    step(1'b0, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 2'b00, 1'b0);
      idle(7);
    end
    check("issued_saturated", int'(bus.RazIssued), STAT ? 15 : 0);

    // Clear coincident with an accepted request.
    step(1'b1, 1'b1, 2'b00, 1'b1);
    check("issued_clear_prio", int'(bus.RazIssued), 0);
    idle(10);

    // Reset in the middle of a 40-cycle pulse.
    step(1'b1, 1'b1, 2'b11, 1'b0);
    idle(4);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_raz",     int'(bus.RAZ_CHN), 0);
    check("midreset_busy",    int'(bus.RazBusy), 0);
    check("midreset_issued",  int'(bus.RazIssued), 0);
    check("midreset_dropped", int'(bus.RazDropped), 0);
    @(posedge Clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    check("post_reset_idle_busy", int'(bus.RazBusy), 0);
    step(1'b1, 1'b1, 2'b00, 1'b0);
    idle(20);
    check("post_reset_issued", int'(bus.RazIssued), STAT ? 1 : 0);

    idle(5);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
